// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin channel selector: mode encodings,
// channel limit and selector-width helper.
package mux_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_FORCED = 1'b1;

  localparam int MAX_CH = 16;

  function automatic int sel_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: search starts one past the last
// winner and wraps, first requester wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH  = 7,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic             enable,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] idx
);

  int               pos;
  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      pos  = (int'(last) + k) % N_CH;
      cand = SEL_W'(pos);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered selector with round-robin or forced channel choice
// and a valid/ready output stage. MUX_RR_BADSEL_EN enables the sticky bad_sel flag.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N_CH  = 7,
  parameter int WIDTH = 32,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] data_in,
  output logic [N_CH-1:0]       grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  bad_sel
);

  if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_n_ch
    $error("mux_rr_n: N_CH out of range");
  end

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [SEL_W-1:0] last;
  logic             accept;
  logic             capture;
  logic             sel_oob;
  logic [SEL_W-1:0] fsel;
  logic [N_CH-1:0]  rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] win_idx;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_data[i] = data_in[i*WIDTH +: WIDTH];
    end
  end

  assign accept  = !out_valid || out_ready;
  // Out-of-range forced selects fall back to channel 0, as the legacy mux did.
  assign sel_oob = (int'(sel) >= N_CH);
  assign fsel    = sel_oob ? '0 : sel;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req    (req),
    .last   (last),
    .enable (accept && !reset && (mode == MODE_RR)),
    .grant  (rr_grant),
    .idx    (rr_idx)
  );

  always_comb begin
    grant   = '0;
    win_idx = '0;
    if (!reset) begin
      if (mode == MODE_FORCED) begin
        if (accept && req[fsel]) begin
          grant[fsel] = 1'b1;
          win_idx     = fsel;
        end
      end else begin
        grant   = rr_grant;
        win_idx = rr_idx;
      end
    end
  end

  assign capture = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ch    <= '0;
      last      <= SEL_W'(N_CH - 1);
    end else if (capture) begin
      out_valid <= 1'b1;
      data_out  <= ch_data[win_idx];
      out_ch    <= win_idx;
      if (mode == MODE_RR) begin
        last <= win_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_BADSEL_EN
  logic bad_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_q <= 1'b0;
    end else if (capture && (mode == MODE_FORCED) && sel_oob) begin
      bad_q <= 1'b1;
    end
  end

  assign bad_sel = bad_q;
`else
  assign bad_sel = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n (N_CH=7, WIDTH=32): vector table of
// per-cycle stimulus and expected grant, scoreboard for captured words.
module tb_mux_rr_n;

  localparam int N  = 7;
  localparam int W  = 32;
  localparam int SW = 3;

`ifdef MUX_RR_BADSEL_EN
  localparam bit BADSEL_EN = 1'b1;
`else
  localparam bit BADSEL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]  grant;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic [SW-1:0] out_ch;
  logic          bad_sel;

  logic [W-1:0] chdat [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) data_in[i*W +: W] = chdat[i];
  end

  mux_rr_n #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_ch    (out_ch),
    .bad_sel   (bad_sel)
  );

  typedef struct packed {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  req;
    logic          rdy;
    logic [N-1:0]  eg;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  logic ov_m   = 1'b0;
  logic bad_m  = 1'b0;
  logic [W-1:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [SW-1:0] s, input logic [N-1:0] r,
                     input logic rd, input logic [N-1:0] eg);
    vec_t v;
    v.mode = m; v.sel = s; v.req = r; v.rdy = rd; v.eg = eg;
    vecs.push_back(v);
  endtask

  task automatic cycle(input string tag, input vec_t v);
    exp_t e;
    int   idx;
    mode = v.mode; sel = v.sel; req = v.req; out_ready = v.rdy;
    @(negedge clk);
    check({tag, " grant"}, 32'(grant), 32'(v.eg));
    if (v.eg != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (v.eg[i]) idx = i;
      e.data = chdat[idx];
      e.ch   = SW'(idx);
      sb.push_back(e);
      ov_m = 1'b1;
      if (v.mode && int'(v.sel) >= N) bad_m = BADSEL_EN;
    end else if (ov_m && v.rdy) begin
      ov_m = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov_m));
    if (v.eg != '0) begin
      if (sb.size() == 0) begin
        check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        held = e.data;
        check({tag, " data_out"}, data_out, e.data);
        check({tag, " out_ch"}, 32'(out_ch), 32'(e.ch));
      end
    end else if (ov_m) begin
      check({tag, " data_out hold"}, data_out, held);
    end
    check({tag, " bad_sel"}, 32'(bad_sel), 32'(bad_m));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " data_out"}, data_out, 32'd0);
    check({tag, " out_ch"}, 32'(out_ch), 32'd0);
    check({tag, " bad_sel"}, 32'(bad_sel), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < N; i++) chdat[i] = 32'h0000_00A0 + 32'(i) * 32'h0000_0101;
    chdat[3] = 32'hDEAD_BEEF;

    // mode, sel, req, rdy, expected grant; rows run back to back
    add(0, 0, 7'b0000101, 1, 7'b0000001);
    add(0, 0, 7'b0000101, 1, 7'b0000100);
    add(0, 0, 7'b0000101, 1, 7'b0000001);
    add(0, 0, 7'b1111111, 1, 7'b0000010);
    add(0, 0, 7'b1111111, 1, 7'b0000100);
    add(0, 0, 7'b1111111, 1, 7'b0001000);
    add(0, 0, 7'b1111111, 1, 7'b0010000);
    add(0, 0, 7'b1111111, 1, 7'b0100000);
    add(0, 0, 7'b1111111, 1, 7'b1000000);
    add(0, 0, 7'b1111111, 1, 7'b0000001);
    add(0, 0, 7'b1111111, 1, 7'b0000010);
    add(0, 0, 7'b1111111, 0, 7'b0000000);
    add(0, 0, 7'b1111111, 0, 7'b0000000);
    add(0, 0, 7'b1111111, 0, 7'b0000000);
    add(0, 0, 7'b1111111, 1, 7'b0000100);
    add(0, 0, 7'b0000000, 1, 7'b0000000);
    add(0, 0, 7'b0000000, 0, 7'b0000000);
    add(0, 0, 7'b0000001, 0, 7'b0000001);
    add(0, 0, 7'b1111111, 0, 7'b0000000);
    add(0, 0, 7'b0000000, 1, 7'b0000000);
    add(1, 3, 7'b0001000, 1, 7'b0001000);
    add(1, 3, 7'b0000000, 1, 7'b0000000);
    add(1, 5, 7'b0001001, 1, 7'b0000000);
    add(0, 0, 7'b1111111, 1, 7'b0000010);
    add(1, 7, 7'b0000001, 1, 7'b0000001);
    add(1, 7, 7'b0000010, 1, 7'b0000000);
    add(0, 0, 7'b1111111, 1, 7'b0000100);

    reset = 1'b1; mode = 1'b0; sel = '0; req = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset grant", 32'(grant), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while a word is held and every channel is requesting.
    mode = 1'b0; sel = '0; req = 7'b1111111; out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrst grant", 32'(grant), 32'd0);
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    sb.delete();
    ov_m = 1'b0; bad_m = 1'b0; held = '0;
    @(negedge clk);
    check("midrst hold grant", 32'(grant), 32'd0);
    @(posedge clk);
    #1;
    check_reset_state("midrst hold");
    reset = 1'b0;

    v.mode = 0; v.sel = '0; v.req = 7'b1111111; v.rdy = 1'b1; v.eg = 7'b0000001;
    cycle("postrst0", v);
    v.eg = 7'b0000010;
    cycle("postrst1", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
